// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared sequencer state encoding for the MIPS core
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multicycle state sequencer with memory/multdiv stalls
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waitrequest,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             multdiv_busy,
  input  logic             halt_req,
  output logic [2:0]       state,
  output logic             ir_wren,
  output logic             pc_wren,
  output logic             active,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q;
  state_t           state_d;
  logic             active_q;
  logic [CNT_W-1:0] count_q;
  logic             stall;
  logic             retire;

  assign stall = ((mem_read | mem_write) & waitrequest) | multdiv_busy;

  always_comb begin
    state_d = state_q;
    ir_wren = 1'b0;
    pc_wren = 1'b0;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        if (!waitrequest) begin
          ir_wren = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (!stall) begin
          if (halt_req) begin
            pc_wren = 1'b1;
            retire  = 1'b1;
            state_d = HALT;
          end else if (mem_read) begin
            state_d = WB;
          end else begin
            pc_wren = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      // load data lands here regardless of waitrequest
      WB: begin
        pc_wren = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    // strobes must never reach the datapath while reset is held
    if (reset) begin
      ir_wren = 1'b0;
      pc_wren = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      active_q <= 1'b1;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= (state_d != HALT);
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign active      = active_q;
  assign instr_count = count_q;

endmodule
